// File: rtl/clk_period_meter_pkg.sv
// Purpose: shared types and constants for the clock period meter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, reset values, averaging group size.
package clk_period_meter_pkg;

    typedef enum logic {
        ST_WAIT    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    localparam state_t RST_STATE   = ST_WAIT;
    localparam logic   RST_VALID   = 1'b0;
    localparam logic   RST_TIMEOUT = 1'b0;
    localparam logic   RST_SYNC    = 1'b0;

    // Number of periods folded into one published average.
    localparam int AVG_GROUP = 4;
    localparam int AVG_SHIFT = $clog2(AVG_GROUP);

endpackage

// File: rtl/clk_period_meter_if.sv
// Purpose: bundle of the measured input and the measurement results.
// Latency: n/a (wires only).
// Backpressure: none; results are strobed and must be taken when valid is high.
// master = meter side (drives results), slave = source/consumer side (drives in).
interface clk_period_meter_if #(
    parameter int n = 16
);
    logic         in;
    logic [n-1:0] period;
    logic [n-1:0] high;
    logic         valid;
    logic         timeout;

    modport master (
        input  in,
        output period,
        output high,
        output valid,
        output timeout
    );

    modport slave (
        output in,
        input  period,
        input  high,
        input  valid,
        input  timeout
    );
endinterface

// File: rtl/clk_period_meter_sync_edge.sv
// Purpose: multi-stage synchronizer for an async level plus edge register.
// Latency: rise/fall pulse and level appear stages+1 clk edges after din is sampled.
// Backpressure: none.
// Ports: clk, reset (sync, active-high), din (async) -> level, rise, fall (clk domain).
module sync_edge
    import clk_period_meter_pkg::*;
#(
    parameter int stages = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [stages-1:0] sq;
    logic              lvl_q;
    logic              rise_q;
    logic              fall_q;

    // rise/fall are registered alongside lvl_q so that both edges carry the
    // same delay and the pulse coincides with the first cycle of the new level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sq     <= {stages{RST_SYNC}};
            lvl_q  <= RST_SYNC;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sq     <= {sq[stages-2:0], din};
            lvl_q  <= sq[stages-1];
            rise_q <= sq[stages-1] & ~lvl_q;
            fall_q <= ~sq[stages-1] & lvl_q;
        end
    end

    assign level = lvl_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/clk_period_meter.sv
// Purpose: measures period and high time of a slow async square wave in clk cycles.
// Latency: valid + period/high one cycle after the detected rise (rise is sync+1 edges after in).
// Backpressure: none; one-cycle valid strobe, results held until the next strobe.
// Ports: clk, reset (sync, active-high), bus (master): in -> period, high, valid, timeout.
// Option: define CLK_PERIOD_METER_AVG_EN to publish the average of every 4 periods.
module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int n    = 16,
    parameter int sync = 2
) (
    input  logic                clk,
    input  logic                reset,
    clk_period_meter_if.master  bus
);

    localparam logic [n-1:0] CNT_MAX = '1;
    localparam logic [n-1:0] CNT_ONE = n'(1);

    logic         level;
    logic         rise;
    logic         fall;

    state_t       state;
    logic [n-1:0] cnt;
    logic [n-1:0] hcnt;
    logic [n-1:0] hshadow;
    logic         fall_seen;

    logic [n-1:0] period_q;
    logic [n-1:0] high_q;
    logic         valid_q;
    logic         timeout_q;

    logic [n-1:0] high_val;
    logic         publish;
    logic [n-1:0] pub_period;
    logic [n-1:0] pub_high;
    logic         saturate;

    sync_edge #(.stages(sync)) u_sync_edge (
        .clk   (clk),
        .reset (reset),
        .din   (bus.in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // Without a fall since the last rise the input glitched high for less than
    // the synchronizer could resolve; report the whole period as high time.
    assign high_val = fall_seen ? hshadow : cnt;
    assign saturate = (state == ST_MEASURE) && !rise && (cnt == CNT_MAX);

`ifdef CLK_PERIOD_METER_AVG_EN
    logic [n+AVG_SHIFT-1:0] acc_p;
    logic [n+AVG_SHIFT-1:0] acc_h;
    logic [n+AVG_SHIFT-1:0] sum_p;
    logic [n+AVG_SHIFT-1:0] sum_h;
    logic [AVG_SHIFT-1:0]   grp;

    assign sum_p      = acc_p + {{AVG_SHIFT{1'b0}}, cnt};
    assign sum_h      = acc_h + {{AVG_SHIFT{1'b0}}, high_val};
    assign publish    = (grp == AVG_SHIFT'(AVG_GROUP - 1));
    assign pub_period = sum_p[n+AVG_SHIFT-1:AVG_SHIFT];
    assign pub_high   = sum_h[n+AVG_SHIFT-1:AVG_SHIFT];

    // Group counter wraps naturally at the group size.
    always_ff @(posedge clk) begin
        if (reset || saturate) begin
            acc_p <= '0;
            acc_h <= '0;
            grp   <= '0;
        end else if (state == ST_MEASURE && rise) begin
            grp <= grp + 1'b1;
            if (publish) begin
                acc_p <= '0;
                acc_h <= '0;
            end else begin
                acc_p <= sum_p;
                acc_h <= sum_h;
            end
        end
    end
`else
    assign publish    = 1'b1;
    assign pub_period = cnt;
    assign pub_high   = high_val;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RST_STATE;
            cnt       <= '0;
            hcnt      <= '0;
            hshadow   <= '0;
            fall_seen <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= RST_VALID;
            timeout_q <= RST_TIMEOUT;
        end else begin
            valid_q <= 1'b0;
            case (state)
                ST_WAIT: begin
                    // First partial period is only used to align; never reported.
                    if (rise) begin
                        cnt       <= CNT_ONE;
                        hcnt      <= CNT_ONE;
                        fall_seen <= 1'b0;
                        timeout_q <= 1'b0;
                        state     <= ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    // rise takes priority over saturation in the same cycle.
                    if (rise) begin
                        if (publish) begin
                            period_q <= pub_period;
                            high_q   <= pub_high;
                            valid_q  <= 1'b1;
                        end
                        cnt       <= CNT_ONE;
                        hcnt      <= CNT_ONE;
                        fall_seen <= 1'b0;
                    end else if (saturate) begin
                        timeout_q <= 1'b1;
                        state     <= ST_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (fall) begin
                            hshadow   <= hcnt;
                            fall_seen <= 1'b1;
                        end else if (level && !fall_seen) begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

    assign bus.period  = period_q;
    assign bus.high    = high_q;
    assign bus.valid   = valid_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Purpose: directed self-checking bench for clk_period_meter (n=8, sync=2).
// Latency: n/a.
// Backpressure: n/a.
module tb_clk_period_meter;

    localparam int N = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    clk_period_meter_if #(.n(N)) bus ();

    clk_period_meter #(.n(N), .sync(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Strobe log, filled on the falling edge.
    int           cyc       = 0;
    int           b2b       = 0;
    int           last_vcyc = 0;
    int           tmo_cyc   = -1;
    logic [N-1:0] vper[$];
    logic [N-1:0] vhigh[$];
    int           vcyc[$];
    logic         prev_valid = 1'b0;
    logic         prev_tmo   = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (bus.valid === 1'b1) begin
            vper.push_back(bus.period);
            vhigh.push_back(bus.high);
            vcyc.push_back(cyc);
            last_vcyc = cyc;
            if (prev_valid) b2b++;
        end
        if (bus.timeout === 1'b1 && !prev_tmo) tmo_cyc = cyc;
        prev_valid = (bus.valid === 1'b1);
        prev_tmo   = (bus.timeout === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        vper.delete();
        vhigh.delete();
        vcyc.delete();
        b2b = 0;
    endtask

    // Holds in at v for k rising edges; starts and ends 1 time unit past an edge.
    task automatic drive_phase(input logic v, input int k);
        bus.in = v;
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in = 1'b0;
        reset  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.period !== 8'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", bus.period); end
        checks++; if (bus.high !== 8'd0) begin failures++; $display("FAIL reset_high got=%0d exp=0", bus.high); end
        checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid); end
        checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", bus.timeout); end
        clear_log();
        reset = 1'b0;
        drive_phase(1'b0, 3);
        checks++; if (vper.size() != 0) begin failures++; $display("FAIL reset_idle_valids got=%0d exp=0", vper.size()); end
    endtask

`ifndef CLK_PERIOD_METER_AVG_EN
    // 80 ns wave, 40 ns high: six rises, the first only starts measuring.
    task automatic test_steady();
        clear_log();
        repeat (6) begin
            drive_phase(1'b1, 4);
            drive_phase(1'b0, 4);
        end
        checks++; if (vper.size() != 5) begin failures++; $display("FAIL steady_count got=%0d exp=5", vper.size()); end
        for (int i = 0; i < vper.size(); i++) begin
            checks++; if (vper[i] !== 8'd8) begin failures++; $display("FAIL steady_period[%0d] got=%0d exp=8", i, vper[i]); end
            checks++; if (vhigh[i] !== 8'd4) begin failures++; $display("FAIL steady_high[%0d] got=%0d exp=4", i, vhigh[i]); end
            if (i > 0) begin
                checks++; if (vcyc[i] - vcyc[i-1] != 8) begin failures++; $display("FAIL steady_spacing[%0d] got=%0d exp=8", i, vcyc[i] - vcyc[i-1]); end
            end
        end
    endtask

    // Switch to 120 ns / 30 ns high; the extra low stretch makes the first report 4+4+5.
    task automatic test_duty_change();
        clear_log();
        drive_phase(1'b0, 5);
        repeat (5) begin
            drive_phase(1'b1, 3);
            drive_phase(1'b0, 9);
        end
        checks++; if (vper.size() != 5) begin failures++; $display("FAIL duty_count got=%0d exp=5", vper.size()); end
        if (vper.size() > 0) begin
            checks++; if (vper[0] !== 8'd13) begin failures++; $display("FAIL duty_mixed_period got=%0d exp=13", vper[0]); end
            checks++; if (vhigh[0] !== 8'd4) begin failures++; $display("FAIL duty_mixed_high got=%0d exp=4", vhigh[0]); end
        end
        for (int i = 1; i < vper.size(); i++) begin
            checks++; if (vper[i] !== 8'd12) begin failures++; $display("FAIL duty_period[%0d] got=%0d exp=12", i, vper[i]); end
            checks++; if (vhigh[i] !== 8'd3) begin failures++; $display("FAIL duty_high[%0d] got=%0d exp=3", i, vhigh[i]); end
        end
    endtask

    task automatic test_timeout();
        int lv;
        clear_log();
        lv      = last_vcyc;
        tmo_cyc = -1;
        bus.in  = 1'b0;
        for (int i = 0; i < 400 && tmo_cyc < 0; i++) @(posedge clk);
        #1;
        checks++; if (tmo_cyc < 0) begin failures++; $display("FAIL timeout_seen got=none exp=asserted within 400 cycles"); end
        checks++; if (tmo_cyc - lv != 255) begin failures++; $display("FAIL timeout_delay got=%0d exp=255", tmo_cyc - lv); end
        checks++; if (vper.size() != 0) begin failures++; $display("FAIL timeout_no_valid got=%0d exp=0", vper.size()); end
        checks++; if (bus.period !== 8'd12) begin failures++; $display("FAIL timeout_period_held got=%0d exp=12", bus.period); end
        checks++; if (bus.high !== 8'd3) begin failures++; $display("FAIL timeout_high_held got=%0d exp=3", bus.high); end
        checks++; if (bus.timeout !== 1'b1) begin failures++; $display("FAIL timeout_level got=%b exp=1", bus.timeout); end
        drive_phase(1'b1, 4);
        drive_phase(1'b0, 4);
        checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL timeout_cleared got=%b exp=0", bus.timeout); end
        checks++; if (vper.size() != 0) begin failures++; $display("FAIL timeout_first_rise_valid got=%0d exp=0", vper.size()); end
        repeat (2) begin
            drive_phase(1'b1, 4);
            drive_phase(1'b0, 4);
        end
        checks++; if (vper.size() != 2) begin failures++; $display("FAIL timeout_resume_count got=%0d exp=2", vper.size()); end
        for (int i = 0; i < vper.size(); i++) begin
            checks++; if (vper[i] !== 8'd8 || vhigh[i] !== 8'd4) begin failures++; $display("FAIL timeout_resume[%0d] got=%0d/%0d exp=8/4", i, vper[i], vhigh[i]); end
        end
    endtask

    task automatic test_mid_reset();
        drive_phase(1'b1, 4);
        drive_phase(1'b0, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (bus.period !== 8'd0) begin failures++; $display("FAIL midrst_period got=%0d exp=0", bus.period); end
        checks++; if (bus.high !== 8'd0) begin failures++; $display("FAIL midrst_high got=%0d exp=0", bus.high); end
        checks++; if (bus.valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus.valid); end
        checks++; if (bus.timeout !== 1'b0) begin failures++; $display("FAIL midrst_timeout got=%b exp=0", bus.timeout); end
        drive_phase(1'b0, 2);
        clear_log();
        repeat (3) begin
            drive_phase(1'b1, 4);
            drive_phase(1'b0, 4);
        end
        checks++; if (vper.size() != 2) begin failures++; $display("FAIL midrst_count got=%0d exp=2", vper.size()); end
        for (int i = 0; i < vper.size(); i++) begin
            checks++; if (vper[i] !== 8'd8 || vhigh[i] !== 8'd4) begin failures++; $display("FAIL midrst_meas[%0d] got=%0d/%0d exp=8/4", i, vper[i], vhigh[i]); end
        end
    endtask

    // 2 high / 2 low; first report still covers the preceding 8-cycle period.
    task automatic test_min_input();
        clear_log();
        repeat (10) begin
            drive_phase(1'b1, 2);
            drive_phase(1'b0, 2);
        end
        drive_phase(1'b0, 4);
        checks++; if (vper.size() != 10) begin failures++; $display("FAIL min_count got=%0d exp=10", vper.size()); end
        if (vper.size() > 0) begin
            checks++; if (vper[0] !== 8'd8 || vhigh[0] !== 8'd4) begin failures++; $display("FAIL min_first got=%0d/%0d exp=8/4", vper[0], vhigh[0]); end
        end
        for (int i = 1; i < vper.size(); i++) begin
            checks++; if (vper[i] !== 8'd4) begin failures++; $display("FAIL min_period[%0d] got=%0d exp=4", i, vper[i]); end
            checks++; if (vhigh[i] !== 8'd2) begin failures++; $display("FAIL min_high[%0d] got=%0d exp=2", i, vhigh[i]); end
        end
        checks++; if (b2b != 0) begin failures++; $display("FAIL min_back_to_back got=%0d exp=0", b2b); end
    endtask
`else
    // Periods 8,8,10,10 (highs 4,4,5,5) average to 9/4; then a group of 8/4.
    task automatic test_average();
        clear_log();
        drive_phase(1'b1, 4); drive_phase(1'b0, 4);
        drive_phase(1'b1, 4); drive_phase(1'b0, 4);
        drive_phase(1'b1, 5); drive_phase(1'b0, 5);
        drive_phase(1'b1, 5); drive_phase(1'b0, 5);
        drive_phase(1'b1, 4); drive_phase(1'b0, 4);
        checks++; if (vper.size() != 1) begin failures++; $display("FAIL avg_count got=%0d exp=1", vper.size()); end
        if (vper.size() > 0) begin
            checks++; if (vper[0] !== 8'd9) begin failures++; $display("FAIL avg_period got=%0d exp=9", vper[0]); end
            checks++; if (vhigh[0] !== 8'd4) begin failures++; $display("FAIL avg_high got=%0d exp=4", vhigh[0]); end
        end
        repeat (4) begin
            drive_phase(1'b1, 4);
            drive_phase(1'b0, 4);
        end
        checks++; if (vper.size() != 2) begin failures++; $display("FAIL avg_count2 got=%0d exp=2", vper.size()); end
        if (vper.size() > 1) begin
            checks++; if (vper[1] !== 8'd8 || vhigh[1] !== 8'd4) begin failures++; $display("FAIL avg_group2 got=%0d/%0d exp=8/4", vper[1], vhigh[1]); end
        end
        checks++; if (b2b != 0) begin failures++; $display("FAIL avg_back_to_back got=%0d exp=0", b2b); end
    endtask
`endif

    initial begin
        bus.in = 1'b0;
        test_reset();
`ifndef CLK_PERIOD_METER_AVG_EN
        test_steady();
        test_duty_change();
        test_timeout();
        test_mid_reset();
        test_min_input();
`else
        test_average();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures the period and high time of a slow, asynchronous square wave, such as the output of the programmable clock divider, in cycles of the system clock. Sits directly downstream of the divider. Provides run-time readback that a commanded `div` setting produced the expected output frequency and duty. Publishes one registered measurement per input period with a one-cycle strobe, and flags loss of input activity.

## Interface
- `n`, 16: width of the period/high counters and outputs, in clk cycles.
- `sync`, 2: synchronizer stages on `in`, ≥2.
- `clk`  in  1: system clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `in`  in  1: measured signal, asynchronous to `clk`.
- `period`  out  n: clk cycles between the last two detected rising edges of `in`.
- `high`  out  n: clk cycles `in` was high within that period.
- `valid`  out  1: one-cycle strobe; `period`/`high` updated this cycle.
- `timeout`  out  1: level; no rising edge for 2^n−1 cycles.

## Operation
- `in` passes through `sync` flops, then an edge register. This yields one-cycle `rise`/`fall` pulses in the clk domain.
- The FSM has two states: WAIT and MEASURE.
- WAIT, the reset state: counters are held.
  - On `rise`: set `cnt`=1 and `hcnt`=1, clear `timeout`, and go to MEASURE.
  - The first partial period after reset or timeout is never reported.
- MEASURE:
  - Every cycle without `rise`: `cnt`++.
  - While the synchronized input is high and no `fall` has occurred since the last `rise`: `hcnt`++.
  - On `fall`: freeze `hcnt` into `hshadow`.
  - On `rise`: `period`←`cnt`, `high`←`hshadow`, `valid`=1 on the next cycle. Then reload `cnt`=1 and `hcnt`=1.
- Saturation: when `cnt` reaches 2^n−1 with no `rise`:
  - `timeout`←1 and state→WAIT.
  - `period`/`high` keep their last values and no `valid` is issued.
- If no `fall` occurs between two rises (an input glitch shorter than the synchronizer can resolve), `high` reports `period`.
- `rise` and saturation in the same cycle: `rise` wins. The measurement is published and `timeout` stays 0.
- Reset mid-measurement discards all counts. The next `rise` starts a fresh WAIT→MEASURE sequence.
- Arithmetic is unsigned. Counters never wrap.

## Timing
- Reset values:
  - `period`=0, `high`=0, `valid`=0, `timeout`=0.
  - State WAIT, synchronizer flops 0.
- Edge latency: an `in` transition is seen as `rise`/`fall` `sync`+1 clk edges after it is sampled.
- Output latency: `valid` and the new `period`/`high` appear together, 1 cycle after `rise`.
- Both `rise` and `fall` delays equal `sync`+1. `period` and `high` are therefore exact to ±1 cycle of sampling jitter.
- Input constraint: each high and low phase of `in` must be ≥2 clk cycles. Shorter phases may be missed; behaviour is then as specified for missing edges.
- `valid` never asserts on two consecutive cycles.

## Configuration
- Macro `CLK_PERIOD_METER_AVG_EN`.
- Defined:
  - Four consecutive periods and highs are summed in (n+2)-bit accumulators.
  - Every 4th `rise` publishes sum>>2 (truncating) with one `valid`.
  - Timeout or reset clears the accumulators and the 2-bit group counter.
- Undefined: every `rise` in MEASURE publishes, as above. No accumulator logic is synthesized.

## Structure
- Shared package: the FSM state encoding (WAIT, MEASURE), the reset value constants, and the averaging group size constant (4).
- Sub-module `sync_edge` holds the `sync`-stage synchronizer plus edge register, with outputs `level`, `rise` and `fall`. The divider's consumers reuse it.
- The top level holds the FSM, counters, shadow register and output registers.

## Test plan
- Reset sequence: `clk` 10 ns, `in` square wave at 80 ns (high 40 ns).
  - No `valid` before the second detected rise.
  - Then `valid` pulses every 8 cycles with `period`=8 and `high`=4.
- Duty change: `in` switches to period 120 ns, high 30 ns.
  - The first `valid` after the change reports a mixed period.
  - Subsequent reports are `period`=12, `high`=3.
- Timeout: n=8, `in` held low after one measurement.
  - `timeout`=1 exactly 255 cycles after the last `rise`.
  - No `valid`; `period` is unchanged.
  - Resuming the wave clears `timeout` at the first rise. `valid` follows the second rise.
- Mid-measurement reset: `reset` pulses 1 cycle at 5 cycles into a period.
  - All outputs read 0 on the next cycle.
  - The next full period reports correctly.
- Averaging (`CLK_PERIOD_METER_AVG_EN`): periods 8, 8, 10, 10.
  - One `valid` with `period`=9 after the 4th period.
  - No `valid` on the intermediate rises.
- Minimum input: `in` high 2, low 2 cycles.
  - `period`=4 and `high`=2 on every strobe.
  - `valid` is never high on back-to-back cycles.
